change_dispenser: RTL
=====================

# change_dispenser

Downstream stage of the vending controller. Takes the change amount produced at the end of a successful transaction and pays it out as physical coins through a single coin-hopper handshake, one coin at a time. Coins are chosen greedily from a per-denomination inventory. The block reports completion, any shortfall, and the unpaid remainder.

## Interface
Parameters:
- CNT_W, 8: width of each per-denomination inventory counter.
- INIT_CNT, 0: inventory value of every denomination after reset.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RESET_N  in  1  reset, asynchronous, active-low.
- I_START  in  1  single-cycle request; captures I_AMOUNT when idle.
- I_AMOUNT  in  16  change to pay, in cents.
- I_LOAD  in  1  add I_LOAD_CNT coins to denomination I_LOAD_DEN.
- I_LOAD_DEN  in  3  denomination code, 0..5.
- I_LOAD_CNT  in  CNT_W  coins to add.
- O_COIN_VALID  out  1  coin request to the hopper.
- O_COIN_DEN  out  3  denomination of the requested coin.
- I_COIN_ACK  in  1  hopper has released the coin.
- O_BUSY  out  1  payout in progress.
- O_DONE  out  1  one-cycle pulse at the end of a payout.
- O_SHORT  out  1  inventory ran out before the remainder reached 0. Valid with O_DONE and held until the next I_START.
- O_REMAIN  out  16  unpaid cents. Valid with O_DONE and held until the next I_START.

## Operation
- Denomination codes and values: 0=1, 1=5, 2=10, 3=25, 4=100, 5=500. Codes 6 and 7 are illegal. A load with an illegal code is ignored.
- States: S_IDLE, S_SELECT, S_ISSUE, S_FINISH.
- S_IDLE:
  - On I_START: latch remain = I_AMOUNT, clear O_SHORT, go to S_SELECT.
  - I_START is ignored in every other state.
- S_SELECT:
  - If remain == 0, go to S_FINISH.
  - Otherwise pick the largest denomination whose value ≤ remain and whose inventory > 0. Register it into O_COIN_DEN and go to S_ISSUE.
  - If no denomination qualifies, go to S_FINISH.
- S_ISSUE:
  - O_COIN_VALID = 1. O_COIN_DEN must stay stable until I_COIN_ACK.
  - On the ACK cycle: remain -= value, inventory[den] -= 1, go to S_SELECT.
- S_FINISH:
  - O_DONE = 1 for one cycle.
  - O_SHORT = (remain != 0), O_REMAIN = remain.
  - Go to S_IDLE.
- O_BUSY = 1 in S_SELECT, S_ISSUE and S_FINISH.
- Inventory loading:
  - I_LOAD is accepted in any state.
  - Addition saturates at 2^CNT_W−1.
  - If a load and an ACK hit the same denomination in the same cycle, the new count is sat(count + LOAD_CNT) − 1.
- Arithmetic: remain is 16-bit. Greedy selection guarantees value ≤ remain, so the subtraction never wraps.
- I_COIN_ACK outside S_ISSUE is ignored.

## Timing
- I_START is sampled in cycle N. S_SELECT is in cycle N+1, and the first O_COIN_VALID is asserted in cycle N+2.
- Each coin costs at least 2 cycles (SELECT plus ISSUE with an immediate ACK).
- ACK in cycle M gives S_SELECT in M+1 and the next O_COIN_VALID in M+2, or O_DONE in M+2.
- An amount of 0 gives O_DONE in cycle N+2 and no coins.
- Reset values:
  - O_COIN_VALID, O_COIN_DEN, O_BUSY, O_DONE, O_SHORT and O_REMAIN are all 0.
  - State is S_IDLE and every inventory counter is INIT_CNT.
- Reset mid-payout takes effect immediately. Any coin in flight is abandoned, and no O_DONE is issued.

## Structure
- Shared package vend_pkg holds:
  - the denomination code constants (DEN_1C … DEN_500C);
  - a function mapping code to 16-bit value;
  - the state encoding.
- Sub-module coin_select is purely combinational. Inputs are remain and six "inventory non-zero" flags. Outputs are the chosen code and a found flag.

## Test plan
- All inventories 10, amount 291: coins 100,100,25,25,25,10,5,1 in that order. O_DONE set, O_SHORT=0, O_REMAIN=0, inventory[100]=8, inventory[25]=7.
- Inventory[25]=2 and all other inventories 0, amount 100: two 25-cent coins, then O_DONE with O_SHORT=1 and O_REMAIN=50.
- Hold I_COIN_ACK low for 5 cycles during the first coin: O_COIN_VALID and O_COIN_DEN stay stable and the inventory is unchanged. On ACK, the decrement happens exactly once.
- Amount 0: O_DONE at N+2, no O_COIN_VALID, O_SHORT=0.
- Inventory[100]=1, amount 100, I_LOAD of 100-cent × 4 on the ACK cycle: inventory[100]=4 afterwards. A second I_START pulsed while busy is ignored.
- Assert reset after the first ACK of a 300 payout: all outputs drop to 0 asynchronously, inventory returns to INIT_CNT, and no O_DONE is seen.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin denomination codes, their cent values and the payout FSM encoding.
package vend_pkg;

  localparam int NUM_DEN = 6;

  localparam logic [2:0] DEN_1C   = 3'd0;
  localparam logic [2:0] DEN_5C   = 3'd1;
  localparam logic [2:0] DEN_10C  = 3'd2;
  localparam logic [2:0] DEN_25C  = 3'd3;
  localparam logic [2:0] DEN_100C = 3'd4;
  localparam logic [2:0] DEN_500C = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_FINISH
  } state_t;

  // Codes 6 and 7 are illegal and map to zero value.
  function automatic logic [15:0] den_value(input logic [2:0] den);
    case (den)
      DEN_1C:   return 16'd1;
      DEN_5C:   return 16'd5;
      DEN_10C:  return 16'd10;
      DEN_25C:  return 16'd25;
      DEN_100C: return 16'd100;
      DEN_500C: return 16'd500;
      default:  return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, inventory-load and coin-hopper signals of the change dispenser; master drives requests, slave is the dispenser.
interface change_dispenser_if #(
  parameter int CNT_W = 8
);
  logic             I_START;
  logic [15:0]      I_AMOUNT;
  logic             I_LOAD;
  logic [2:0]       I_LOAD_DEN;
  logic [CNT_W-1:0] I_LOAD_CNT;
  logic             O_COIN_VALID;
  logic [2:0]       O_COIN_DEN;
  logic             I_COIN_ACK;
  logic             O_BUSY;
  logic             O_DONE;
  logic             O_SHORT;
  logic [15:0]      O_REMAIN;

  modport master (
    output I_START, I_AMOUNT, I_LOAD, I_LOAD_DEN, I_LOAD_CNT, I_COIN_ACK,
    input  O_COIN_VALID, O_COIN_DEN, O_BUSY, O_DONE, O_SHORT, O_REMAIN
  );

  modport slave (
    input  I_START, I_AMOUNT, I_LOAD, I_LOAD_DEN, I_LOAD_CNT, I_COIN_ACK,
    output O_COIN_VALID, O_COIN_DEN, O_BUSY, O_DONE, O_SHORT, O_REMAIN
  );
endinterface

// File: rtl/coin_select.sv
// Greedy coin picker: largest stocked denomination not exceeding remain; purely combinational, no backpressure.
module coin_select
  import vend_pkg::*;
(
  input  logic [15:0]        remain,
  input  logic [NUM_DEN-1:0] inv_nz,
  output logic [2:0]         den,
  output logic               found
);

  // Ascending scan so the last qualifying (largest) denomination wins.
  always_comb begin
    den   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_DEN; i++) begin
      if (inv_nz[i] && (den_value(3'(i)) <= remain)) begin
        den   = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time from per-denomination inventory; first coin 2 cycles after start,
// at least 2 cycles per coin; a coin request holds until the hopper acks, loads are accepted at any time.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int          CNT_W    = 8,
  parameter int unsigned INIT_CNT = 0
) (
  input logic                I_CLK,
  input logic                I_RESET_N,
  change_dispenser_if.slave  bus
);

  state_t      state_q, state_d;
  logic [15:0] remain_q;
  logic [2:0]  den_q;
  logic        short_q;
  logic [15:0] remain_out_q;

  logic        start_ld, sel_ld, fin_ld, coin_take;
  logic [NUM_DEN-1:0] inv_nz;
  logic [2:0]  sel_den;
  logic        sel_found;

  coin_select u_coin_select (
    .remain (remain_q),
    .inv_nz (inv_nz),
    .den    (sel_den),
    .found  (sel_found)
  );

  always_comb begin
    state_d   = state_q;
    start_ld  = 1'b0;
    sel_ld    = 1'b0;
    fin_ld    = 1'b0;
    coin_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.I_START) begin
          start_ld = 1'b1;
          state_d  = S_SELECT;
        end
      end
      // remain == 0 never finds a coin, so it falls through to FINISH too.
      S_SELECT: begin
        if (sel_found) begin
          sel_ld  = 1'b1;
          state_d = S_ISSUE;
        end else begin
          fin_ld  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_ISSUE: begin
        if (bus.I_COIN_ACK) begin
          coin_take = 1'b1;
          state_d   = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q      <= S_IDLE;
      remain_q     <= 16'd0;
      den_q        <= 3'd0;
      short_q      <= 1'b0;
      remain_out_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (start_ld)       remain_q <= bus.I_AMOUNT;
      else if (coin_take) remain_q <= remain_q - den_value(den_q);
      if (sel_ld) den_q <= sel_den;
      if (start_ld)    short_q <= 1'b0;
      else if (fin_ld) short_q <= (remain_q != 16'd0);
      if (fin_ld) remain_out_q <= remain_q;
    end
  end

  // Load and take on the same counter combine as saturate-then-decrement.
  for (genvar g = 0; g < NUM_DEN; g++) begin : g_inv
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sat;
    logic             ld_hit, take_hit;

    assign ld_hit   = bus.I_LOAD && (bus.I_LOAD_DEN == 3'(g));
    assign take_hit = coin_take && (den_q == 3'(g));
    assign sum      = {1'b0, cnt_q} + {1'b0, (ld_hit ? bus.I_LOAD_CNT : {CNT_W{1'b0}})};
    assign sat      = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    assign inv_nz[g] = |cnt_q;

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) cnt_q <= CNT_W'(INIT_CNT);
      else            cnt_q <= sat - CNT_W'(take_hit);
    end
  end

  assign bus.O_COIN_VALID = (state_q == S_ISSUE);
  assign bus.O_COIN_DEN   = den_q;
  assign bus.O_BUSY       = (state_q != S_IDLE);
  assign bus.O_DONE       = (state_q == S_FINISH);
  assign bus.O_SHORT      = short_q;
  assign bus.O_REMAIN     = remain_out_q;

endmodule
